// File: rtl/cipher_pkg.sv
// cipher_pkg: shared states, constants and helpers for the cipher stream controller
package cipher_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ACCEPT = 3'd1;
  localparam state_t S_CALC   = 3'd2;
  localparam state_t S_CAPT   = 3'd3;
  localparam state_t S_OUT    = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam logic [8:0] P_MOD       = 9'd227;
  localparam logic [7:0] NULL_CHAR   = 8'h00;
  localparam logic [7:0] LC_LO       = 8'h61;
  localparam logic [7:0] LC_HI       = 8'h7A;
  localparam logic [1:0] MODE_CIPHER = 2'b10;
  localparam logic [1:0] MODE_IDLE   = 2'b00;

  // Counter increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return v + {7'd0, v != 8'hFF};
  endfunction
endpackage

// File: rtl/encryption.sv
// encryption: registered per-character core, Char_ciphertext = (Plaintext - Public_key) mod 227 for 'a'..'z'
module encryption
  import cipher_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] Plaintext,
  input  logic [7:0] Public_key,
  output logic [7:0] Char_ciphertext,
  output logic       C_ready
);
  logic [8:0] diff;
  logic [8:0] wrap;
  logic       valid;
  logic [7:0] ct_d, ct_q;
  logic       rdy_d, rdy_q;

  // Subtract in 9 bits; a borrow means the result is negative and must be folded back by the modulus
  always_comb begin
    diff  = {1'b0, Plaintext} - {1'b0, Public_key};
    wrap  = diff + P_MOD;
    valid = (Plaintext >= LC_LO) && (Plaintext <= LC_HI);
    ct_d  = (mode == MODE_CIPHER) ? (valid ? (diff[8] ? wrap[7:0] : diff[7:0]) : NULL_CHAR) : ct_q;
    rdy_d = (mode == MODE_CIPHER) ? valid : rdy_q;
  end

  // Result register, refreshed only while the controller requests a cipher
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      ct_q  <= ct_d;
      rdy_q <= rdy_d;
    end
  end

  assign Char_ciphertext = ct_q;
  assign C_ready         = rdy_q;
endmodule

// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl: message-level FSM feeding one character at a time through the encryption core
module cipher_stream_ctrl
  import cipher_pkg::*;
#(
  parameter int MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] key,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_char,
  output logic       out_err,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic       len_ovf,
  output logic [7:0] char_count,
  output logic [7:0] err_count
);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  state_t     state_d, state_q;
  logic [7:0] key_d, key_q, ch_d, ch_q, out_char_d, out_char_q;
  logic [7:0] char_count_d, char_count_q, err_count_d, err_count_q;
  logic       out_err_d, out_err_q, len_ovf_d, len_ovf_q, cfg_err_d, cfg_err_q;
  logic [7:0] core_ct;
  logic       core_rdy;
  logic [1:0] mode;

  assign mode = (state_q == S_CALC || state_q == S_CAPT) ? MODE_CIPHER : MODE_IDLE;

  encryption u_core (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode            (mode),
    .Plaintext       (ch_q),
    .Public_key      (key_q),
    .Char_ciphertext (core_ct),
    .C_ready         (core_rdy)
  );

  // Next-state and datapath updates; abort overrides everything and freezes the counters
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    ch_d         = ch_q;
    out_char_d   = out_char_q;
    out_err_d    = out_err_q;
    char_count_d = char_count_q;
    err_count_d  = err_count_q;
    len_ovf_d    = len_ovf_q;
    cfg_err_d    = 1'b0;
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (start) begin
        if (key != NULL_CHAR && {1'b0, key} < P_MOD) begin
          key_d        = key;
          char_count_d = '0;
          err_count_d  = '0;
          len_ovf_d    = 1'b0;
          state_d      = S_ACCEPT;
        end else cfg_err_d = 1'b1;
      end
      S_ACCEPT: if (in_valid) begin
        ch_d    = (in_char == NULL_CHAR) ? ch_q : in_char;
        state_d = (in_char == NULL_CHAR) ? S_DONE : S_CALC;
      end
      S_CALC: state_d = S_CAPT;
      S_CAPT: begin
        out_char_d   = core_ct;
        out_err_d    = !core_rdy;
        char_count_d = sat_inc(char_count_q);
        err_count_d  = core_rdy ? err_count_q : sat_inc(err_count_q);
        state_d      = S_OUT;
      end
      S_OUT: if (out_ready) begin
        len_ovf_d = len_ovf_q | (char_count_q == MAX_L);
        state_d   = (char_count_q == MAX_L) ? S_DONE : S_ACCEPT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      key_q        <= '0;
      ch_q         <= '0;
      out_char_q   <= '0;
      out_err_q    <= 1'b0;
      char_count_q <= '0;
      err_count_q  <= '0;
      len_ovf_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      ch_q         <= ch_d;
      out_char_q   <= out_char_d;
      out_err_q    <= out_err_d;
      char_count_q <= char_count_d;
      err_count_q  <= err_count_d;
      len_ovf_q    <= len_ovf_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign busy       = state_q != S_IDLE;
  assign in_ready   = state_q == S_ACCEPT;
  assign out_valid  = state_q == S_OUT;
  assign done       = state_q == S_DONE;
  assign out_char   = out_char_q;
  assign out_err    = out_err_q;
  assign cfg_err    = cfg_err_q;
  assign len_ovf    = len_ovf_q;
  assign char_count = char_count_q;
  assign err_count  = err_count_q;
endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// tb_cipher_stream_ctrl: directed scoreboard bench for the cipher stream controller
module tb_cipher_stream_ctrl;
  localparam int MAXL = 4;

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] key = 8'h00, in_char = 8'h00;
  logic       in_ready, out_valid, out_err, busy, done, cfg_err, len_ovf;
  logic [7:0] out_char, char_count, err_count;

  typedef struct packed {logic [7:0] ch; logic err;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int lat;
  logic [7:0] held;

  cipher_stream_ctrl #(.MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key(key),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .out_valid(out_valid), .out_char(out_char), .out_err(out_err), .out_ready(out_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err), .len_ovf(len_ovf),
    .char_count(char_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] c, input logic [7:0] k);
    exp_t e;
    int r;
    if (c >= 8'h61 && c <= 8'h7A) begin
      r = int'(c) - int'(k);
      if (r < 0) r += 227;
      e.ch = 8'(r);
      e.err = 1'b0;
    end else begin
      e.ch = 8'h00;
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic do_start(input logic [7:0] k);
    key = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] k, input bit push);
    int n = 0;
    in_valid = 1'b1;
    in_char = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_handshake", 32'(n < 50), 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (push && c != 8'h00) sb.push_back(model(c, k));
  endtask

  task automatic recv(output int l);
    exp_t e;
    l = 0;
    while (!out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    chk("out_valid_seen", out_valid, 1);
    if (sb.size() == 0) chk("scoreboard_nonempty", 0, 1);
    else begin
      e = sb.pop_front();
      chk("out_char", out_char, e.ch);
      chk("out_err", out_err, e.err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_len_ovf", len_ovf, 0);
    chk("rst_char_count", char_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // key 5, "a" then terminator
    do_start(8'd5);
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    send(8'h61, 8'd5, 1);
    chk("t1_in_ready_calc", in_ready, 0);
    recv(lat);
    chk("t1_latency", lat, 2);
    send(8'h00, 8'd5, 1);
    chk("t1_done", done, 1);
    chk("t1_char_count", char_count, 1);
    chk("t1_err_count", err_count, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_count_hold", char_count, 1);
    // key 200 "z", key 1 "b"
    do_start(8'd200);
    send(8'h7A, 8'd200, 1);
    recv(lat);
    send(8'h00, 8'd200, 1);
    @(negedge clk);
    do_start(8'd1);
    send(8'h62, 8'd1, 1);
    recv(lat);
    send(8'h00, 8'd1, 1);
    @(negedge clk);
    // key 3: 'A' invalid, 'c' valid
    do_start(8'd3);
    send(8'h41, 8'd3, 1);
    recv(lat);
    send(8'h63, 8'd3, 1);
    recv(lat);
    send(8'h00, 8'd3, 1);
    chk("t3_done", done, 1);
    chk("t3_err_count", err_count, 1);
    chk("t3_char_count", char_count, 2);
    @(negedge clk);
    // rejected keys
    do_start(8'd227);
    chk("t4_cfg_err_227", cfg_err, 1);
    chk("t4_busy_227", busy, 0);
    @(negedge clk);
    chk("t4_cfg_err_pulse", cfg_err, 0);
    do_start(8'd0);
    chk("t4_cfg_err_0", cfg_err, 1);
    chk("t4_busy_0", busy, 0);
    @(negedge clk);
    // start while busy is ignored
    do_start(8'd7);
    key = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4b_no_cfg_err_busy", cfg_err, 0);
    chk("t4b_still_accept", in_ready, 1);
    // backpressure: out_ready low for 10 cycles
    out_ready = 1'b0;
    send(8'h64, 8'd7, 1);
    recv(lat);
    held = out_char;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_stable", out_char, held);
      chk("t5_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    send(8'h65, 8'd7, 1);
    recv(lat);
    send(8'h00, 8'd7, 1);
    @(negedge clk);
    // length limit without terminator
    do_start(8'd9);
    for (int i = 0; i < MAXL; i++) begin
      send(8'h68 + 8'(i), 8'd9, 1);
      recv(lat);
    end
    @(negedge clk);
    chk("t6_done", done, 1);
    chk("t6_len_ovf", len_ovf, 1);
    chk("t6_char_count", char_count, MAXL);
    @(negedge clk);
    chk("t6_len_ovf_sticky", len_ovf, 1);
    do_start(8'd5);
    chk("t6_len_ovf_clear", len_ovf, 0);
    chk("t6_count_clear", char_count, 0);
    send(8'h00, 8'd5, 1);
    @(negedge clk);
    // abort in S_OUT
    do_start(8'd5);
    out_ready = 1'b0;
    send(8'h67, 8'd5, 1);
    recv(lat);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_busy", busy, 0);
    chk("t7_out_valid", out_valid, 0);
    chk("t7_done", done, 0);
    chk("t7_count_hold", char_count, 1);
    @(negedge clk);
    chk("t7_no_done", done, 0);
    out_ready = 1'b1;
    // reset during S_CAPT
    do_start(8'd5);
    send(8'h66, 8'd5, 0);
    @(negedge clk);
    chk("t8_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_out_valid", out_valid, 0);
    chk("t8_out_char", out_char, 0);
    chk("t8_char_count", char_count, 0);
    chk("t8_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t8_idle_after", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
